dma_channel_regs: RTL and testbench

- Per-channel register file of the DMA controller. It sits directly downstream of the host register-access decoder and consumes its load/read strobes.
- Holds four channels' 16-bit base/current address and base/current word-count registers. These are programmed and read through the 8-bit data bus using the internal byte-pointer flip-flop.
- Applies per-transfer address/count updates from the timing unit, autoinitialisation and terminal-count (TC) detection.

---
 rtl/dma_regs_pkg.sv | 45 ++++
 rtl/dma_byte_ptr.sv | 49 ++++
 rtl/dma_channel_regs.sv | 174 +++++++++++++++++
 tb/tb_dma_channel_regs.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_regs_pkg.sv
// Shared types and helpers for the DMA per-channel register file.
// Optional feature macro used by the top: DMA_CHREG_ADDR_HOLD_EN.
package dma_regs_pkg;

  localparam int NUM_CH = 4;
  localparam int WORD_W = 16;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef logic [1:0]        chIdx_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOW_BYTE  = 1'b0,
    HIGH_BYTE = 1'b1
  } bytePtr_t;

  // Strobe bundle index map.
  localparam int STB_LD_ADDR = 0;
  localparam int STB_LD_CNT  = 1;
  localparam int STB_RD_ADDR = 2;
  localparam int STB_RD_CNT  = 3;
  localparam int STB_STATUS  = 4;
  localparam int STB_CLR_FF  = 5;
  localparam int NUM_STB     = 6;

  function automatic word_t setByte(
    input word_t      w,
    input bytePtr_t   p,
    input logic [7:0] b
  );
    word_t r;
    r = w;
    if (p == HIGH_BYTE) r[15:8] = b;
    else                r[7:0]  = b;
    return r;
  endfunction

  function automatic logic [7:0] getByte(
    input word_t    w,
    input bytePtr_t p
  );
    return (p == HIGH_BYTE) ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/dma_byte_ptr.sv
// Strobe rise detection and the shared byte-pointer flip-flop.
// Pointer toggles on any load/read rise; clear-FF rise forces LOW.
module dma_byte_ptr
  import dma_regs_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic [NUM_STB-1:0] strobe_i,
  output logic [NUM_STB-1:0] accessRise_o,
  output bytePtr_t           ptr_o
);

  logic [NUM_STB-1:0] strobe_q;
  bytePtr_t           ptr_q;
  bytePtr_t           ptr_d;
  logic               toggle;

  assign accessRise_o = strobe_i & ~strobe_q;
  assign ptr_o        = ptr_q;

  assign toggle = accessRise_o[STB_LD_ADDR]
                | accessRise_o[STB_LD_CNT]
                | accessRise_o[STB_RD_ADDR]
                | accessRise_o[STB_RD_CNT];

  always_comb begin
    ptr_d = ptr_q;
    unique case (1'b1)
      accessRise_o[STB_CLR_FF]: ptr_d = LOW_BYTE;
      toggle:                   ptr_d = bytePtr_t'(~ptr_q);
      default:                  ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_q <= '0;
      ptr_q    <= LOW_BYTE;
    end else if (clr_i) begin
      strobe_q <= strobe_i;
      ptr_q    <= LOW_BYTE;
    end else begin
      strobe_q <= strobe_i;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: rtl/dma_channel_regs.sv
// DMA per-channel base/current address and word-count registers.
// Define DMA_CHREG_ADDR_HOLD_EN to let addrHold freeze curAddr.
module dma_channel_regs
  import dma_regs_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              masterClear,
  input  chIdx_t            channelSel,
  input  logic [7:0]        dataIn,
  input  logic              loadBaseAddressReg,
  input  logic              loadBaseWordCountReg,
  input  logic              readCurrentAddressReg,
  input  logic              readCurrentWordCountReg,
  input  logic              readStatusReg,
  input  logic              clearInternalFF,
  output logic [7:0]        dataOut,
  output logic              dataOutValid,
  input  chIdx_t            activeChannel,
  input  logic              addrUpdate,
  input  logic              addrDecrement,
  input  logic              autoInit,
  input  logic              addrHold,
  output word_t             currentAddress,
  output logic              terminalCount,
  output logic [NUM_CH-1:0] tcStatus
);

  logic [NUM_STB-1:0] stb;
  logic [NUM_STB-1:0] rise;
  bytePtr_t           ptr;

  word_t baseAddr_q [NUM_CH];
  word_t baseAddr_d [NUM_CH];
  word_t baseCnt_q  [NUM_CH];
  word_t baseCnt_d  [NUM_CH];
  word_t curAddr_q  [NUM_CH];
  word_t curAddr_d  [NUM_CH];
  word_t curCnt_q   [NUM_CH];
  word_t curCnt_d   [NUM_CH];

  logic [7:0]        dataOut_q, dataOut_d;
  logic              valid_q, valid_d;
  logic              tc_q, tc_d;
  logic [NUM_CH-1:0] tcStatus_q, tcStatus_d;

  logic wrAddr, wrCnt, rdAddr, rdCnt, stRise;
  logic rdLevel, collide, updEn, tcHit, holdEn;

`ifdef DMA_CHREG_ADDR_HOLD_EN
  assign holdEn = addrHold;
`else
  logic unused_addrHold;
  assign holdEn          = 1'b0;
  assign unused_addrHold = addrHold;
`endif

  assign stb[STB_LD_ADDR] = loadBaseAddressReg;
  assign stb[STB_LD_CNT]  = loadBaseWordCountReg;
  assign stb[STB_RD_ADDR] = readCurrentAddressReg;
  assign stb[STB_RD_CNT]  = readCurrentWordCountReg;
  assign stb[STB_STATUS]  = readStatusReg;
  assign stb[STB_CLR_FF]  = clearInternalFF;

  dma_byte_ptr u_ptr (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .clr_i        (masterClear),
    .strobe_i     (stb),
    .accessRise_o (rise),
    .ptr_o        (ptr)
  );

  assign wrAddr  = rise[STB_LD_ADDR];
  assign wrCnt   = rise[STB_LD_CNT];
  assign rdAddr  = rise[STB_RD_ADDR];
  assign rdCnt   = rise[STB_RD_CNT];
  assign stRise  = rise[STB_STATUS];
  assign rdLevel = readCurrentAddressReg | readCurrentWordCountReg;

  // A host write to the serviced channel swallows that cycle's update.
  assign collide = (wrAddr | wrCnt) && (channelSel == activeChannel);
  assign updEn   = addrUpdate && !collide;
  assign tcHit   = updEn && (curCnt_q[activeChannel] == '0);

  assign currentAddress = curAddr_q[activeChannel];
  assign dataOut        = dataOut_q;
  assign dataOutValid   = valid_q;
  assign terminalCount  = tc_q;
  assign tcStatus       = tcStatus_q;

  always_comb begin
    baseAddr_d = baseAddr_q;
    baseCnt_d  = baseCnt_q;
    curAddr_d  = curAddr_q;
    curCnt_d   = curCnt_q;

    if (updEn) begin
      if (tcHit && autoInit) begin
        curAddr_d[activeChannel] = baseAddr_q[activeChannel];
        curCnt_d[activeChannel]  = baseCnt_q[activeChannel];
      end else begin
        if (!holdEn) begin
          curAddr_d[activeChannel] = addrDecrement
            ? curAddr_q[activeChannel] - 16'd1
            : curAddr_q[activeChannel] + 16'd1;
        end
        curCnt_d[activeChannel] = curCnt_q[activeChannel] - 16'd1;
      end
    end

    if (wrAddr) begin
      baseAddr_d[channelSel] = setByte(baseAddr_q[channelSel], ptr, dataIn);
      curAddr_d[channelSel]  = setByte(curAddr_q[channelSel], ptr, dataIn);
    end
    if (wrCnt) begin
      baseCnt_d[channelSel] = setByte(baseCnt_q[channelSel], ptr, dataIn);
      curCnt_d[channelSel]  = setByte(curCnt_q[channelSel], ptr, dataIn);
    end
  end

  always_comb begin
    dataOut_d = dataOut_q;
    unique case (1'b1)
      rdAddr:   dataOut_d = getByte(curAddr_q[channelSel], ptr);
      rdCnt:    dataOut_d = getByte(curCnt_q[channelSel], ptr);
      !rdLevel: dataOut_d = 8'h00;
      default:  dataOut_d = dataOut_q;
    endcase
    valid_d = rdLevel;
  end

  always_comb begin
    tc_d       = tcHit;
    tcStatus_d = stRise ? '0 : tcStatus_q;
    if (tcHit) tcStatus_d[activeChannel] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        baseAddr_q[i] <= '0;
        baseCnt_q[i]  <= '0;
        curAddr_q[i]  <= '0;
        curCnt_q[i]   <= '0;
      end
      dataOut_q  <= '0;
      valid_q    <= 1'b0;
      tc_q       <= 1'b0;
      tcStatus_q <= '0;
    end else if (masterClear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        baseAddr_q[i] <= '0;
        baseCnt_q[i]  <= '0;
        curAddr_q[i]  <= '0;
        curCnt_q[i]   <= '0;
      end
      dataOut_q  <= '0;
      valid_q    <= 1'b0;
      tc_q       <= 1'b0;
      tcStatus_q <= '0;
    end else begin
      baseAddr_q <= baseAddr_d;
      baseCnt_q  <= baseCnt_d;
      curAddr_q  <= curAddr_d;
      curCnt_q   <= curCnt_d;
      dataOut_q  <= dataOut_d;
      valid_q    <= valid_d;
      tc_q       <= tc_d;
      tcStatus_q <= tcStatus_d;
    end
  end

endmodule

// File: tb/tb_dma_channel_regs.sv
// Self-checking bench for dma_channel_regs: vector table plus
// scoreboarded readback and hand-written update/TC sequences.
module tb_dma_channel_regs;
  import dma_regs_pkg::*;

  logic        CLK;
  logic        RESET_N;
  logic        masterClear;
  chIdx_t      channelSel;
  logic [7:0]  dataIn;
  logic        loadBaseAddressReg;
  logic        loadBaseWordCountReg;
  logic        readCurrentAddressReg;
  logic        readCurrentWordCountReg;
  logic        readStatusReg;
  logic        clearInternalFF;
  logic [7:0]  dataOut;
  logic        dataOutValid;
  chIdx_t      activeChannel;
  logic        addrUpdate;
  logic        addrDecrement;
  logic        autoInit;
  logic        addrHold;
  word_t       currentAddress;
  logic        terminalCount;
  logic [3:0]  tcStatus;

  dma_channel_regs dut (
    .CLK                     (CLK),
    .RESET_N                 (RESET_N),
    .masterClear             (masterClear),
    .channelSel              (channelSel),
    .dataIn                  (dataIn),
    .loadBaseAddressReg      (loadBaseAddressReg),
    .loadBaseWordCountReg    (loadBaseWordCountReg),
    .readCurrentAddressReg   (readCurrentAddressReg),
    .readCurrentWordCountReg (readCurrentWordCountReg),
    .readStatusReg           (readStatusReg),
    .clearInternalFF         (clearInternalFF),
    .dataOut                 (dataOut),
    .dataOutValid            (dataOutValid),
    .activeChannel           (activeChannel),
    .addrUpdate              (addrUpdate),
    .addrDecrement           (addrDecrement),
    .autoInit                (autoInit),
    .addrHold                (addrHold),
    .currentAddress          (currentAddress),
    .terminalCount           (terminalCount),
    .tcStatus                (tcStatus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit     cnt;
    chIdx_t ch;
    word_t  val;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] sb  [$];
  int         nVec;
  int         nErr;
  logic       p1, p2;
  word_t      holdExp;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input bit cnt, input chIdx_t ch,
                    input logic [7:0] b, input bit upd);
    channelSel = ch;
    dataIn     = b;
    addrUpdate = upd;
    if (cnt) loadBaseWordCountReg = 1'b1;
    else     loadBaseAddressReg   = 1'b1;
    tick();
    loadBaseWordCountReg = 1'b0;
    loadBaseAddressReg   = 1'b0;
    addrUpdate           = 1'b0;
    tick();
  endtask

  task automatic clrPtr();
    clearInternalFF = 1'b1;
    tick();
    clearInternalFF = 1'b0;
    tick();
  endtask

  task automatic wrWord(input bit cnt, input chIdx_t ch, input word_t w);
    clrPtr();
    wr(cnt, ch, w[7:0], 1'b0);
    wr(cnt, ch, w[15:8], 1'b0);
  endtask

  task automatic rd(input bit cnt, input chIdx_t ch,
                    input logic [7:0] exp, input string nm);
    logic       got;
    logic [7:0] e;
    sb.push_back(exp);
    channelSel = ch;
    if (cnt) readCurrentWordCountReg = 1'b1;
    else     readCurrentAddressReg   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge CLK);
      if (dataOutValid) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      nVec++;
      nErr++;
      $display("FAIL %s: dataOutValid never rose, expected byte %0h", nm, e);
    end else begin
      chk(nm, dataOut, e);
    end
    @(posedge CLK);
    #1;
    chk({nm, "_validHold"}, dataOutValid, 1'b1);
    readCurrentWordCountReg = 1'b0;
    readCurrentAddressReg   = 1'b0;
    tick();
    chk({nm, "_drop"}, {dataOutValid, dataOut}, 9'h000);
  endtask

  task automatic rdWord(input bit cnt, input chIdx_t ch, input word_t w,
                        input string nm);
    clrPtr();
    rd(cnt, ch, w[7:0], {nm, "_lo"});
    rd(cnt, ch, w[15:8], {nm, "_hi"});
  endtask

  task automatic upd(output logic a, output logic b);
    addrUpdate = 1'b1;
    tick();
    addrUpdate = 1'b0;
    a = terminalCount;
    tick();
    b = terminalCount;
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    RESET_N = 1'b0;
    masterClear = 1'b0;
    channelSel = '0;
    dataIn = '0;
    loadBaseAddressReg = 1'b0;
    loadBaseWordCountReg = 1'b0;
    readCurrentAddressReg = 1'b0;
    readCurrentWordCountReg = 1'b0;
    readStatusReg = 1'b0;
    clearInternalFF = 1'b0;
    activeChannel = '0;
    addrUpdate = 1'b0;
    addrDecrement = 1'b0;
    autoInit = 1'b0;
    addrHold = 1'b0;

    tbl[0] = '{0, 2'd0, 16'h1234};
    tbl[1] = '{1, 2'd0, 16'hA5C3};
    tbl[2] = '{0, 2'd1, 16'h0F0F};
    tbl[3] = '{1, 2'd1, 16'h8001};
    tbl[4] = '{0, 2'd2, 16'hFFFE};
    tbl[5] = '{1, 2'd2, 16'h00FF};
    tbl[6] = '{0, 2'd3, 16'h5A5A};
    tbl[7] = '{1, 2'd3, 16'h7E81};

    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    chk("rst_out", {dataOutValid, dataOut, terminalCount}, 10'h000);
    chk("rst_tcStatus", tcStatus, 4'h0);
    chk("rst_curAddr", currentAddress, 16'h0000);

    foreach (tbl[i]) wrWord(tbl[i].cnt, tbl[i].ch, tbl[i].val);
    foreach (tbl[i]) rdWord(tbl[i].cnt, tbl[i].ch, tbl[i].val,
                            $sformatf("tbl%0d", i));

    wrWord(1'b0, 2'd2, 16'h1234);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    chk("midrst_tcStatus", tcStatus, 4'h0);
    for (int c = 0; c < 4; c++) begin
      rdWord(1'b0, chIdx_t'(c), 16'h0000, $sformatf("midrst_a%0d", c));
      rdWord(1'b1, chIdx_t'(c), 16'h0000, $sformatf("midrst_c%0d", c));
    end

    wrWord(1'b0, 2'd1, 16'hBEEF);
    clrPtr();
    wr(1'b1, 2'd1, 8'h05, 1'b0);
    wr(1'b1, 2'd1, 8'h00, 1'b0);
    rdWord(1'b1, 2'd1, 16'h0005, "ch1cnt");
    clrPtr();
    rd(1'b0, 2'd1, 8'hEF, "ptr_rd1");
    clrPtr();
    rd(1'b0, 2'd1, 8'hEF, "ptr_rd2");
    rd(1'b0, 2'd1, 8'hBE, "ptr_rd3");

    wrWord(1'b0, 2'd0, 16'hFFFF);
    wrWord(1'b1, 2'd0, 16'h0010);
    activeChannel = 2'd0;
    #1;
    chk("wrap_start", currentAddress, 16'hFFFF);
    upd(p1, p2);
    chk("wrap_inc", currentAddress, 16'h0000);
    addrDecrement = 1'b1;
    upd(p1, p2);
    chk("wrap_dec", currentAddress, 16'hFFFF);
    addrDecrement = 1'b0;
    rdWord(1'b1, 2'd0, 16'h000E, "wrap_cnt");
    chk("wrap_tcStatus", tcStatus, 4'h0);

    wrWord(1'b1, 2'd3, 16'h0001);
    wrWord(1'b0, 2'd3, 16'h1000);
    activeChannel = 2'd3;
    autoInit = 1'b1;
    upd(p1, p2);
    chk("ai_tc_u1", {p1, p2}, 2'b00);
    upd(p1, p2);
    chk("ai_tc_u2", {p1, p2}, 2'b10);
    upd(p1, p2);
    chk("ai_tc_u3", {p1, p2}, 2'b00);
    chk("ai_tcStatus", tcStatus, 4'b1000);
    chk("ai_addr", currentAddress, 16'h1001);
    rdWord(1'b1, 2'd3, 16'h0000, "ai_cnt");
    readStatusReg = 1'b1;
    addrUpdate = 1'b1;
    tick();
    readStatusReg = 1'b0;
    addrUpdate = 1'b0;
    chk("st_tcWins", tcStatus, 4'b1000);
    chk("st_reload", currentAddress, 16'h1000);
    tick();
    readStatusReg = 1'b1;
    tick();
    readStatusReg = 1'b0;
    tick();
    chk("st_clear", tcStatus, 4'h0);
    autoInit = 1'b0;

    activeChannel = 2'd1;
    clrPtr();
    wr(1'b0, 2'd1, 8'h11, 1'b1);
    chk("col_same_addr", currentAddress, 16'hBE11);
    rdWord(1'b1, 2'd1, 16'h0005, "col_same_cnt");
    clrPtr();
    wr(1'b0, 2'd2, 8'h22, 1'b1);
    chk("col_diff_addr1", currentAddress, 16'hBE12);
    rdWord(1'b1, 2'd1, 16'h0004, "col_diff_cnt1");
    rdWord(1'b0, 2'd2, 16'h0022, "col_diff_addr2");

`ifdef DMA_CHREG_ADDR_HOLD_EN
    holdExp = 16'h0100;
`else
    holdExp = 16'h0104;
`endif
    wrWord(1'b0, 2'd0, 16'h0100);
    activeChannel = 2'd0;
    addrHold = 1'b1;
    for (int i = 0; i < 4; i++) upd(p1, p2);
    addrHold = 1'b0;
    chk("hold_addr", currentAddress, holdExp);
    rdWord(1'b1, 2'd0, 16'h000A, "hold_cnt");

    masterClear = 1'b1;
    tick();
    masterClear = 1'b0;
    tick();
    chk("mclr_addr", currentAddress, 16'h0000);
    rdWord(1'b1, 2'd0, 16'h0000, "mclr_cnt");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
